// File: rtl/bloom_lookup_arbiter.sv
// Round-robin arbiter sharing one bloom-filter lookup engine among NUM_REQ header queues.
// Latency: accept at T, bf_start at T+1, result valid one cycle after bf_ready_res (or after TIMEOUT wait cycles).
// Backpressure: one lookup in flight; no grant while a result waits for res_ready or the filter drops bf_ready_recv.
module bloom_lookup_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_slot,
    input  logic [NUM_REQ*104-1:0] req_header,
    output logic [71:0]            bf_ip_pro,
    output logic                   bf_start,
    input  logic                   bf_ready_recv,
    input  logic                   bf_ready_res,
    input  logic                   bf_result,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output logic [31:0]            res_slot,
    output logic                   res_hit,
    output logic                   res_timeout,
    output logic [15:0]            timeout_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [15:0]   TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [ID_W:0] N_REQ   = (ID_W+1)'(NUM_REQ);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [ID_W-1:0]       r_id;
    logic [31:0]           r_slot;
    logic [71:0]           r_key;
    logic                  r_hit;
    logic                  r_to;
    logic [15:0]           r_wait_cnt;
    logic [15:0]           r_to_cnt;

    logic                  w_gnt_any;
    logic [ID_W-1:0]       w_gnt_id;
    logic [ID_W:0]         w_cand;
    logic                  w_accept;
    logic                  w_wait_last;
    logic [NUM_REQ*32-1:0] w_unused_ports;

    // Port numbers in the header never reach the filter key.
    always_comb begin
        w_unused_ports = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_unused_ports[32*i +: 32] = req_header[104*i +: 32];
        end
    end

    // Scan from the highest offset down so the nearest requester after rr_ptr wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_cand >= N_REQ) begin
                w_cand = w_cand - N_REQ;
            end
            if (req_valid[w_cand[ID_W-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = w_cand[ID_W-1:0];
            end
        end
    end

    assign w_accept    = reset && (r_state == S_IDLE) && bf_ready_recv && w_gnt_any;
    assign w_wait_last = (r_wait_cnt == TO_LAST);

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (bf_ready_res || w_wait_last) w_state_nxt = S_RESP;
            S_RESP:  if (res_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_id       <= '0;
            r_slot     <= '0;
            r_key      <= '0;
            r_hit      <= 1'b0;
            r_to       <= 1'b0;
            r_wait_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_id     <= w_gnt_id;
                        r_slot   <= req_slot[32*w_gnt_id +: 32];
                        r_key    <= req_header[104*w_gnt_id + 32 +: 72];
                        r_rr_ptr <= (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
                    end
                end
                S_ISSUE: r_wait_cnt <= '0;
                S_WAIT: begin
                    if (bf_ready_res) begin
                        r_hit <= bf_result;
                        r_to  <= 1'b0;
                    end else if (w_wait_last) begin
                        // Forced result defaults to hit so the CPU makes the final call.
                        r_hit <= 1'b1;
                        r_to  <= 1'b1;
                        if (r_to_cnt != 16'hFFFF) begin
                            r_to_cnt <= r_to_cnt + 16'd1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bf_ip_pro   = r_key;
    assign bf_start    = (r_state == S_ISSUE);
    assign res_valid   = (r_state == S_RESP);
    assign res_id      = r_id;
    assign res_slot    = r_slot;
    assign res_hit     = r_hit;
    assign res_timeout = r_to;
    assign timeout_cnt = r_to_cnt;

endmodule

// File: tb/tb_bloom_lookup_arbiter.sv
// Randomized scoreboard bench for bloom_lookup_arbiter with a transaction-level arbiter/filter model.
module tb_bloom_lookup_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*32-1:0]  req_slot = '0;
    logic [N*104-1:0] req_header = '0;
    logic [71:0]      bf_ip_pro;
    logic             bf_start;
    logic             bf_ready_recv = 1'b0;
    logic             bf_ready_res = 1'b0;
    logic             bf_result = 1'b0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [IDW-1:0]   res_id;
    logic [31:0]      res_slot;
    logic             res_hit;
    logic             res_timeout;
    logic [15:0]      timeout_cnt;

    always #5 clk = ~clk;

    bloom_lookup_arbiter #(.NUM_REQ(N), .ID_W(IDW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_slot(req_slot), .req_header(req_header),
        .bf_ip_pro(bf_ip_pro), .bf_start(bf_start),
        .bf_ready_recv(bf_ready_recv), .bf_ready_res(bf_ready_res), .bf_result(bf_result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_slot(res_slot), .res_hit(res_hit),
        .res_timeout(res_timeout), .timeout_cnt(timeout_cnt)
    );

    typedef struct {
        int          id;
        logic [31:0] slot;
        logic        hit;
        logic        to;
        int          cyc;
        int          tcnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Transaction model state
    logic        m_busy = 1'b0;
    int          m_rr = 0;
    logic        m_acc_prev = 1'b0;
    int          m_id = 0;
    logic [31:0] m_slot = '0;
    logic [71:0] m_key = '0;
    int          m_resc = 0;
    int          m_tcnt = 0;
    // Filter model state and response mode (0 random, 1 fixed, 2 never, 3 quick)
    logic        f_armed = 1'b0;
    logic        f_pend = 1'b0;
    int          f_cnt = 0;
    logic        f_res = 1'b0;
    int          fm_kind = 0;
    int          fm_j = 2;
    logic        fm_res = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Filter: answers after the chosen delay, otherwise sprinkles stray strobes outside WAIT.
    always @(posedge clk) begin
        #1;
        bf_ready_res = 1'b0;
        bf_result    = 1'($urandom % 2);
        if (reset) begin
            if (f_pend) begin
                f_cnt--;
                if (f_cnt == 0) begin
                    bf_ready_res = 1'b1;
                    bf_result    = f_res;
                    f_pend       = 1'b0;
                end
            end else if (!f_armed && ($urandom % 4 == 0)) begin
                bf_ready_res = 1'b1;
            end
        end
    end

    logic [N-1:0] g_exp;
    int           g_sel;
    int           g_j;
    logic         g_r;
    exp_t         g_e;

    always @(negedge clk) begin
        if (reset) begin
            g_exp = '0;
            g_sel = -1;
            if (!m_busy && bf_ready_recv) begin
                for (int k = 0; k < N; k++) begin
                    if (g_sel < 0 && req_valid[(m_rr + k) % N]) g_sel = (m_rr + k) % N;
                end
            end
            if (g_sel >= 0) g_exp[g_sel] = 1'b1;
            chk("req_ready", req_ready, g_exp);
            chk("bf_start", bf_start, m_acc_prev);
            if (m_acc_prev) begin
                chk("bf_ip_pro", bf_ip_pro, m_key);
                case (fm_kind)
                    1: g_j = fm_j;
                    2: g_j = 0;
                    3: g_j = 1 + int'($urandom % 2);
                    default: begin
                        int r;
                        r = int'($urandom % 20);
                        if (r < 14)      g_j = 1 + int'($urandom % TO);
                        else if (r < 17) g_j = TO + 1;
                        else             g_j = 0;
                    end
                endcase
                g_r = (fm_kind == 1) ? fm_res : 1'($urandom % 2);
                g_e.id   = m_id;
                g_e.slot = m_slot;
                if (g_j >= 1 && g_j <= TO) begin
                    g_e.hit = g_r;
                    g_e.to  = 1'b0;
                    g_e.cyc = cyc + g_j + 1;
                end else begin
                    g_e.hit = 1'b1;
                    g_e.to  = 1'b1;
                    g_e.cyc = cyc + TO + 1;
                    if (m_tcnt < 65535) m_tcnt++;
                end
                g_e.tcnt = m_tcnt;
                sb.push_back(g_e);
                m_resc  = g_e.cyc;
                f_armed = 1'b1;
                if (g_j > 0) begin
                    f_pend = 1'b1;
                    f_cnt  = g_j;
                    f_res  = g_r;
                end
            end
            m_acc_prev = 1'b0;
            if (g_sel >= 0) begin
                m_busy     = 1'b1;
                m_rr       = (g_sel + 1) % N;
                m_id       = g_sel;
                m_slot     = req_slot[g_sel*32 +: 32];
                m_key      = req_header[g_sel*104 + 32 +: 72];
                m_acc_prev = 1'b1;
            end else if (m_busy && f_armed && cyc >= m_resc && res_ready) begin
                m_busy  = 1'b0;
                f_armed = 1'b0;
            end
        end
    end

    // Monitor: latency, stability under backpressure and result contents.
    logic        p_rv = 1'b0;
    logic        p_hs = 1'b0;
    logic [IDW-1:0] s_id;
    logic [31:0] s_slot;
    logic        s_hit;
    logic        s_to;
    exp_t        mo_e;

    always @(negedge clk) begin
        if (!reset) begin
            p_rv = 1'b0;
            p_hs = 1'b0;
        end else begin
            if (p_hs) begin
                chk("res_valid_drop", res_valid, 1'b0);
            end else if (res_valid && !p_rv) begin
                if (sb.size() == 0) chk("res_unexpected", res_valid, 1'b0);
                else                chk("res_latency", cyc, sb[0].cyc);
            end
            if (res_valid && p_rv && !p_hs) begin
                chk("hold_id", res_id, s_id);
                chk("hold_slot", res_slot, s_slot);
                chk("hold_hit", res_hit, s_hit);
                chk("hold_timeout", res_timeout, s_to);
            end
            if (res_valid && res_ready && sb.size() > 0) begin
                mo_e = sb.pop_front();
                chk("res_id", res_id, mo_e.id);
                chk("res_slot", res_slot, mo_e.slot);
                chk("res_hit", res_hit, mo_e.hit);
                chk("res_timeout", res_timeout, mo_e.to);
                chk("timeout_cnt", timeout_cnt, mo_e.tcnt);
            end
            p_rv   = res_valid;
            p_hs   = res_valid && res_ready;
            s_id   = res_id;
            s_slot = res_slot;
            s_hit  = res_hit;
            s_to   = res_timeout;
        end
    end

    task automatic drive_cycle(input logic [N-1:0] v, input int rr_pct, input int recv_pct);
        @(posedge clk);
        #1;
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_slot[i*32 +: 32] = $urandom;
            req_header[i*104 +: 104] = {$urandom, $urandom, $urandom, 8'($urandom)};
        end
        res_ready     = (int'($urandom % 100) < rr_pct);
        bf_ready_recv = (int'($urandom % 100) < recv_pct);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_bf_start", bf_start, 1'b0);
        chk("rst_timeout_cnt", timeout_cnt, 16'd0);
        chk("rst_res_slot", res_slot, 32'd0);
        m_busy = 1'b0; m_rr = 0; m_acc_prev = 1'b0; m_tcnt = 0;
        f_armed = 1'b0; f_pend = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        #23;
        chk("reset_res_valid", res_valid, 1'b0);
        chk("reset_req_ready", req_ready, '0);
        chk("reset_bf_start", bf_start, 1'b0);
        chk("reset_bf_ip_pro", bf_ip_pro, 72'd0);
        chk("reset_res_id", res_id, '0);
        chk("reset_res_slot", res_slot, 32'd0);
        chk("reset_res_hit", res_hit, 1'b0);
        chk("reset_res_timeout", res_timeout, 1'b0);
        chk("reset_timeout_cnt", timeout_cnt, 16'd0);
        #5;
        reset = 1'b1;

        // Single directed lookup, filter answers miss two cycles after bf_start.
        fm_kind = 1; fm_j = 2; fm_res = 1'b0;
        drive_cycle(4'b0001, 100, 100);
        req_slot[31:0] = 32'd5;
        req_header[103:0] = {72'hC0A80001_0A000001_06, 32'hABCD_1234};
        repeat (10) drive_cycle(4'b0000, 100, 100);

        // All requesters busy, quick filter.
        fm_kind = 3;
        repeat (30) drive_cycle(4'b1111, 100, 100);
        repeat (8) drive_cycle(4'b0000, 100, 100);

        // Backpressured hit on slot 9.
        fm_kind = 1; fm_j = 2; fm_res = 1'b1;
        drive_cycle(4'b0010, 0, 100);
        req_slot = {32'd9, 32'd9, 32'd9, 32'd9};
        repeat (14) drive_cycle(4'b1111, 0, 100);
        fm_kind = 3;
        repeat (10) drive_cycle(4'b1111, 100, 100);

        // Timeouts.
        fm_kind = 2;
        repeat (30) drive_cycle(4'b0100, 100, 100);

        // Filter not ready to receive.
        fm_kind = 3;
        repeat (8) drive_cycle(4'b0000, 100, 100);
        repeat (6) drive_cycle(4'b0100, 100, 0);
        repeat (6) drive_cycle(4'b0100, 100, 100);

        // Random traffic.
        fm_kind = 0;
        repeat (1500) drive_cycle(4'($urandom), 75, 80);

        // Reset during WAIT, then during RESP.
        fm_kind = 2;
        n = 0;
        while (!f_armed && n < 60) begin
            drive_cycle(4'b1111, 100, 100);
            n++;
        end
        chk("reach_wait", f_armed, 1'b1);
        repeat (3) drive_cycle(4'b1111, 100, 100);
        async_reset();
        fm_kind = 3;
        repeat (12) drive_cycle(4'b1111, 100, 100);
        n = 0;
        while (!res_valid && n < 40) begin
            drive_cycle(4'b1111, 0, 100);
            n++;
        end
        chk("reach_resp", res_valid, 1'b1);
        async_reset();
        repeat (20) drive_cycle(4'b1111, 100, 100);

        // Drain.
        n = 0;
        while (m_busy && n < 200) begin
            drive_cycle(4'b0000, 100, 100);
            n++;
        end
        repeat (3) drive_cycle(4'b0000, 100, 100);
        chk("drain_idle", m_busy, 1'b0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
